// File: rtl/ntt_core_gf64_sign_lift.sv
// Centred sign lift for GF(p), p = 2^W - 2^(W/2) + 1.
// Maps any W-bit input to the representative in [-(p-1)/2, +(p-1)/2],
// sign-extended to OUT_W bits, through a 3-stage valid/ready pipeline.
// Also keeps a saturating count of non-canonical inputs (a >= p).
module ntt_core_gf64_sign_lift #(
  parameter int         MOD_NTT_W = 64,
  parameter int         OUT_W     = MOD_NTT_W + 1,
  parameter int         IN_PIPE   = 1,
  parameter int         SIDE_W    = 0,
  parameter logic [1:0] RST_SIDE  = 2'b00,
  parameter int         CNT_W     = 16,
  localparam int        SW        = (SIDE_W > 0) ? SIDE_W : 1
) (
  input  logic                 clk,
  input  logic                 s_rst,
  input  logic [MOD_NTT_W-1:0] a,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [SW-1:0]        in_side,
  output logic [OUT_W-1:0]     z,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [SW-1:0]        out_side,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     noncanon_cnt
);

  localparam int W = MOD_NTT_W;
  localparam logic [W:0]   ONE  = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]   P    = (ONE << W) - (ONE << (W / 2)) + ONE;
  localparam logic [W-1:0] HALF = W'((P - ONE) >> 1);
  // Side reset: bit 0 wins (reset to 0), else bit 1 (reset to 1), else none.
  localparam bit   SIDE_RST = |RST_SIDE;
  localparam logic SIDE_RV  = ~RST_SIDE[0];

  generate
    if (MOD_NTT_W % 2 != 0) begin : g_bad_w
      $fatal(1, "MOD_NTT_W must be even");
    end
    if (OUT_W < MOD_NTT_W) begin : g_bad_out_w
      $fatal(1, "OUT_W must be >= MOD_NTT_W");
    end
  endgenerate

  // Handshake: a transfer happens on a cycle where valid & ready are both 1.
  // A stage loads when its slot is empty or its content moves on
  // (en_k = ~vld_k | en_(k+1)); in_rdy is combinational from out_rdy.
  logic en0, en1, en2;
  logic vld0, vld1, vld2;
  logic [W-1:0]  a0;
  logic [SW-1:0] side0, side1, side2;

  assign en2    = ~vld2 | out_rdy;
  assign en1    = ~vld1 | en2;
  assign in_rdy = en0;

  // ---------------- stage s0: optional input register ----------------
  generate
    if (IN_PIPE != 0) begin : g_s0
      logic          vld0_q;
      logic [W-1:0]  a0_q;
      logic [SW-1:0] side0_q;

      assign en0   = ~vld0_q | en1;
      assign vld0  = vld0_q;
      assign a0    = a0_q;
      assign side0 = side0_q;

      // s0 occupancy
      always_ff @(posedge clk) begin
        if (s_rst)    vld0_q <= 1'b0;
        else if (en0) vld0_q <= in_vld;
      end

      // s0 data capture (not reset)
      always_ff @(posedge clk) begin
        if (en0 && in_vld) a0_q <= a;
      end

      // s0 side capture, optionally reset
      always_ff @(posedge clk) begin
        if (SIDE_RST && s_rst)   side0_q <= {SW{SIDE_RV}};
        else if (en0 && in_vld) side0_q <= in_side;
      end
    end else begin : g_s0_comb
      assign en0   = en1;
      assign vld0  = in_vld;
      assign a0    = a;
      assign side0 = in_side;
    end
  endgenerate

  // ---------------- stage s1: single conditional subtract -------------
  // 2^W < 2p, so one subtraction always lands in [0, p).
  logic [W:0]   d;
  logic         ge_c;
  logic [W-1:0] r_c;
  logic [W-1:0] r1;
  logic         ge1;

  assign d    = {1'b0, a0} - P;
  assign ge_c = ~d[W];
  assign r_c  = ge_c ? d[W-1:0] : a0;

  // s1 occupancy
  always_ff @(posedge clk) begin
    if (s_rst)    vld1 <= 1'b0;
    else if (en1) vld1 <= vld0;
  end

  // s1 data capture (not reset)
  always_ff @(posedge clk) begin
    if (en1 && vld0) begin
      r1  <= r_c;
      ge1 <= ge_c;
    end
  end

  // s1 side capture, optionally reset
  always_ff @(posedge clk) begin
    if (SIDE_RST && s_rst) side1 <= {SW{SIDE_RV}};
    else if (en1 && vld0)  side1 <= side0;
  end

  // ---------------- stage s2: centring ---------------------------------
  // Upper half of [0, p) becomes r - p (negative); r = 0 stays plain zero.
  logic             neg_c;
  logic [W:0]       diff;
  logic [OUT_W-1:0] z_c;
  logic [OUT_W-1:0] z2;

  assign neg_c = r1 > HALF;
  assign diff  = {1'b0, r1} - P;
  assign z_c   = neg_c ? OUT_W'($signed(diff)) : OUT_W'(r1);

  // s2 occupancy
  always_ff @(posedge clk) begin
    if (s_rst)    vld2 <= 1'b0;
    else if (en2) vld2 <= vld1;
  end

  // s2 data capture (not reset)
  always_ff @(posedge clk) begin
    if (en2 && vld1) z2 <= z_c;
  end

  // s2 side capture, optionally reset
  always_ff @(posedge clk) begin
    if (SIDE_RST && s_rst) side2 <= {SW{SIDE_RV}};
    else if (en2 && vld1)  side2 <= side1;
  end

  // ---------------- non-canonical counter ------------------------------
  logic [CNT_W-1:0] cnt;

  // Count words with a >= p as they leave s1; clear beats increment.
  always_ff @(posedge clk) begin
    if (s_rst || cnt_clr)
      cnt <= '0;
    else if (vld1 && ge1 && en1 && (cnt != '1))
      cnt <= cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
  end

  assign z            = z2;
  assign out_vld      = vld2;
  assign out_side     = side2;
  assign noncanon_cnt = cnt;

endmodule
